// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: state encoding
// and the instruction word loaded into the IR on reset.
package cpu_mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } mc_state_t;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/mc_retire_cnt.sv
// Retired-instruction counter: clears on reset, increments once per retire
// strobe and wraps from all-ones back to zero.
module mc_retire_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   // Count retires; natural modulo-2^CNT_W wrap of the adder.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (inc) begin
         count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cpu_mc_ctrl.sv
// Multi-cycle sequencer for the RV32I core. Walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, talks req/ack to instruction and data memory,
// and owns the PC, IR, register-file write gating, halt/fault state and the
// retired-instruction counter. Decoder/execute/regfile sit combinationally
// around it and see the latched IR.
module cpu_mc_ctrl
   import cpu_mc_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      ir,
   input  logic             reg_we,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             is_halt,
   input  logic [XLEN-1:0]  alu_result,
   input  logic [XLEN-1:0]  nextpc,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [XLEN-1:0]  dmem_addr,
   input  logic             dmem_ack,
   output logic             rf_we,
   output logic [XLEN-1:0]  pc,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             halted,
   output logic             fault
);

   mc_state_t       state_q, state_d;
   logic [XLEN-1:0] pc_q;
   logic [31:0]     ir_q;
   logic [XLEN-1:0] alu_q;
   logic [XLEN-1:0] npc_q;
   logic            ld_q, st_q;
   logic            halted_q, fault_q;
   logic            misaligned;

   assign misaligned = (nextpc[1:0] != 2'b00);

   // Next-state and strobe decode; reset forces every strobe low so a
   // transaction in flight is abandoned in the reset cycle itself.
   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      rf_we    = 1'b0;
      retire   = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (is_halt) begin
               state_d = S_HALT;
               retire  = 1'b1;
            end else if (misaligned) begin
               state_d = S_HALT;
            end else if (is_load || is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = ld_q | st_q;
            if (dmem_ack) state_d = S_WB;
         end
         S_WB: begin
            // Stores never write the register file, whatever reg_we says.
            rf_we   = reg_we & ~st_q;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
      if (rst) begin
         state_d  = S_FETCH;
         imem_req = 1'b0;
         dmem_req = 1'b0;
         rf_we    = 1'b0;
         retire   = 1'b0;
      end
   end

   // State, PC, IR, EXEC snapshot and sticky halt/fault registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= NOP_INSN;
         alu_q    <= '0;
         npc_q    <= '0;
         ld_q     <= 1'b0;
         st_q     <= 1'b0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_FETCH: begin
               if (imem_ack) ir_q <= imem_rdata;
            end
            S_EXEC: begin
               alu_q <= alu_result;
               npc_q <= nextpc;
               ld_q  <= is_load;
               st_q  <= is_store;
               if (is_halt) begin
                  halted_q <= 1'b1;
               end else if (misaligned) begin
                  halted_q <= 1'b1;
                  fault_q  <= 1'b1;
               end
            end
            S_WB: begin
               pc_q <= npc_q;
            end
            default: begin
            end
         endcase
      end
   end

   mc_retire_cnt #(
      .CNT_W (CNT_W)
   ) u_retire_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (retire),
      .count (instret)
   );

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign dmem_addr = alu_q;
   assign dmem_we   = dmem_req & st_q;
   assign halted    = halted_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// Directed bench for cpu_mc_ctrl. A second instance with a 2-bit counter
// runs in lockstep on the same stimulus to exercise counter wrap.
module tb_cpu_mc_ctrl;

   localparam logic [31:0] ADDI   = 32'h0010_0093;
   localparam logic [31:0] LW     = 32'h1000_2103;
   localparam logic [31:0] SW     = 32'h2030_2023;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] BEQ    = 32'h0000_0363;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, imem_ack, dmem_ack;
   logic [31:0] imem_rdata, alu_result, nextpc;
   logic        reg_we, is_load, is_store, is_halt;

   logic        imem_req, dmem_req, dmem_we, rf_we, retire, halted, fault;
   logic [31:0] imem_addr, ir, dmem_addr, pc, instret;

   logic        n_imem_req, n_dmem_req, n_dmem_we, n_rf_we, n_retire, n_halted, n_fault;
   logic [31:0] n_imem_addr, n_ir, n_dmem_addr, n_pc;
   logic [1:0]  n_instret;

   int errors = 0;
   int checks = 0;

   cpu_mc_ctrl dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir(ir), .reg_we(reg_we), .is_load(is_load), .is_store(is_store), .is_halt(is_halt),
      .alu_result(alu_result), .nextpc(nextpc),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .pc(pc), .retire(retire), .instret(instret), .halted(halted), .fault(fault)
   );

   cpu_mc_ctrl #(.CNT_W(2)) dut_n (
      .clk(clk), .rst(rst),
      .imem_req(n_imem_req), .imem_addr(n_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir(n_ir), .reg_we(reg_we), .is_load(is_load), .is_store(is_store), .is_halt(is_halt),
      .alu_result(alu_result), .nextpc(nextpc),
      .dmem_req(n_dmem_req), .dmem_we(n_dmem_we), .dmem_addr(n_dmem_addr), .dmem_ack(dmem_ack),
      .rf_we(n_rf_we), .pc(n_pc), .retire(n_retire), .instret(n_instret), .halted(n_halted), .fault(n_fault)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_dec(input logic rwe, input logic ld, input logic st, input logic hlt,
                          input logic [31:0] alu, input logic [31:0] npc);
      reg_we     = rwe;
      is_load    = ld;
      is_store   = st;
      is_halt    = hlt;
      alu_result = alu;
      nextpc     = npc;
   endtask

   initial begin
      int bad;
      rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;
      set_dec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick; tick;

      // Reset state
      chk("rst_imem_req", imem_req, 0);
      chk("rst_pc", pc, 0);
      chk("rst_ir", ir, 32'h0000_0013);
      chk("rst_instret", instret, 0);
      chk("rst_halt_fault", {halted, fault}, 0);
      chk("rst_strobes", {dmem_req, rf_we, retire}, 0);

      // ADDI, zero-wait fetch
      rst = 1'b0; settle;
      chk("addi_f_req", imem_req, 1);
      chk("addi_f_addr", imem_addr, 0);
      imem_ack = 1'b1; imem_rdata = ADDI;
      tick;                                   // DECODE
      chk("addi_d_ir", ir, ADDI);
      chk("addi_d_req", imem_req, 0);
      imem_ack = 1'b0;
      set_dec(1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 32'h4);
      tick;                                   // EXEC
      chk("addi_e_strobes", {rf_we, retire, dmem_req}, 0);
      tick;                                   // WB
      chk("addi_w_rfwe", rf_we, 1);
      chk("addi_w_retire", retire, 1);
      chk("addi_w_pc", pc, 0);
      tick;                                   // FETCH
      chk("addi_pc", pc, 4);
      chk("addi_instret", instret, 1);
      chk("addi_next_addr", {imem_req, imem_addr}, {1'b1, 32'h4});

      // LW at 0x100, dmem_ack after 3 wait cycles
      imem_ack = 1'b1; imem_rdata = LW;
      tick;                                   // DECODE
      imem_ack = 1'b0;
      set_dec(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h8);
      tick;                                   // EXEC
      chk("lw_e_dreq", dmem_req, 0);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;   // stray ack, req low
      tick;                                   // MEM 1
      imem_ack = 1'b0;
      chk("lw_m1_req_we", {dmem_req, dmem_we}, 2'b10);
      chk("lw_m1_addr", dmem_addr, 32'h100);
      chk("lw_m1_other", {imem_req, rf_we}, 0);
      chk("lw_ir_kept", ir, LW);
      alu_result = 32'h999;
      tick;                                   // MEM 2
      chk("lw_m2", {dmem_req, dmem_addr}, {1'b1, 32'h100});
      tick;                                   // MEM 3
      chk("lw_m3_req", dmem_req, 1);
      tick;                                   // MEM 4
      chk("lw_m4_req", dmem_req, 1);
      dmem_ack = 1'b1;
      tick;                                   // WB
      dmem_ack = 1'b0;
      chk("lw_w_rfwe", rf_we, 1);
      chk("lw_w_retire_dreq", {retire, dmem_req}, 2'b10);
      tick;                                   // FETCH
      chk("lw_pc", pc, 8);
      chk("lw_instret", instret, 2);

      // SW with reg_we forced high
      imem_ack = 1'b1; imem_rdata = SW;
      tick;
      imem_ack = 1'b0;
      set_dec(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'hC);
      tick;                                   // EXEC
      tick;                                   // MEM
      chk("sw_m_req_we", {dmem_req, dmem_we}, 2'b11);
      chk("sw_m_addr", dmem_addr, 32'h200);
      dmem_ack = 1'b1;
      tick;                                   // WB
      dmem_ack = 1'b0;
      chk("sw_w_rfwe", rf_we, 0);
      chk("sw_w_retire", retire, 1);
      tick;
      chk("sw_pc", pc, 32'hC);
      chk("sw_instret", instret, 3);
      chk("sw_n_instret", n_instret, 3);

      // Halt instruction
      imem_ack = 1'b1; imem_rdata = EBREAK;
      tick;
      imem_ack = 1'b0;
      set_dec(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h10);
      tick;                                   // EXEC
      chk("halt_e_retire", {retire, rf_we}, 2'b10);
      tick;                                   // HALT
      chk("halt_flags", {halted, fault}, 2'b10);
      chk("halt_instret", instret, 4);
      chk("halt_pc", pc, 32'hC);
      chk("halt_n_instret_wrap", n_instret, 0);
      chk("halt_n_flags", {n_halted, n_fault, n_imem_req, n_dmem_req, n_dmem_we, n_rf_we, n_retire}, 7'b1000000);
      chk("halt_n_pc_addr", {n_pc, n_imem_addr}, {32'hC, 32'hC});
      chk("halt_n_ir_daddr", {n_ir, n_dmem_addr}, {EBREAK, 32'h0});
      bad = 0;
      imem_ack = 1'b1; dmem_ack = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (imem_req || dmem_req || rf_we || retire) bad++;
      end
      imem_ack = 1'b0; dmem_ack = 1'b0;
      chk("halt_quiet", bad, 0);
      chk("halt_frozen", {pc, instret}, {32'hC, 32'h4});

      // Reset out of HALT
      rst = 1'b1;
      set_dec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick;
      chk("rst2_state", {pc, instret, 30'b0, halted, fault}, 64'h0);
      rst = 1'b0; settle;

      // Misaligned branch target -> fault
      imem_ack = 1'b1; imem_rdata = BEQ;
      tick;
      imem_ack = 1'b0;
      set_dec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h6);
      tick;                                   // EXEC
      chk("fault_e_retire", retire, 0);
      tick;                                   // HALT
      chk("fault_flags", {halted, fault}, 2'b11);
      chk("fault_pc_cnt", {pc, instret}, 64'h0);
      tick;
      chk("fault_quiet", {imem_req, pc}, 33'h0);

      // Reset, one ADDI to move the PC, then reset during a LW memory wait
      rst = 1'b1;
      set_dec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick;
      rst = 1'b0; settle;
      chk("rst3_flags", {halted, fault}, 0);
      imem_ack = 1'b1; imem_rdata = ADDI;
      tick;
      imem_ack = 1'b0;
      set_dec(1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 32'h4);
      tick; tick; tick;                       // EXEC, WB, FETCH
      chk("pre_pc_cnt", {pc, instret}, {32'h4, 32'h1});
      imem_ack = 1'b1; imem_rdata = LW;
      tick;
      imem_ack = 1'b0;
      set_dec(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h8);
      tick;                                   // EXEC
      tick;                                   // MEM wait
      chk("midmem_req", dmem_req, 1);
      rst = 1'b1; settle;
      chk("midmem_rst_drop", {dmem_req, imem_req, rf_we, retire}, 0);
      tick;
      chk("midmem_after_pc", pc, 0);
      chk("midmem_after_cnt", {instret, 31'b0, dmem_req}, 64'h0);
      rst = 1'b0; settle;
      chk("midmem_fetch", {imem_req, imem_addr}, {1'b1, 32'h0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_mc_ctrl.md
Name: cpu_mc_ctrl

Overview:
Multi-cycle sequencer for the RV32I core. It replaces the single-cycle PC/writeback path with an explicit FETCH/DECODE/EXEC/MEM/WB state machine and req/ack handshakes to instruction and data memory, so multi-cycle memories can be attached. It owns the PC, the instruction register, register-file write gating, the halt/fault state and a retired-instruction counter. Decoder, execute and register file stay combinational around it.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  XLEN  fetch address (equals pc)
imem_ack  in  1  fetch done; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
ir  out  32  latched instruction to decoder
reg_we  in  1  decoder register-write enable
is_load  in  1  decoder load flag
is_store  in  1  decoder store flag
is_halt  in  1  decoder halt flag
alu_result  in  XLEN  execute result / memory address
nextpc  in  XLEN  execute next PC
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
dmem_addr  out  XLEN  registered alu_result
dmem_ack  in  1  data access done; load data valid this cycle
rf_we  out  1  gated register-file write strobe
pc  out  XLEN  current PC
retire  out  1  one-cycle pulse per retired instruction
instret  out  CNT_W  retired-instruction count
halted  out  1  sticky; core stopped
fault  out  1  sticky; misaligned next PC detected

Behaviour:
- Reset (synchronous, active-high, priority over everything): state=FETCH, pc=RESET_PC, ir=32'h0000_0013 (NOP), instret=0, halted=0, fault=0, alu_q=0, npc_q=0. All handshake and strobe outputs are low in the reset cycle.
- FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack. On ack: ir<=imem_rdata, go to DECODE.
- DECODE: one cycle for register-file read. Go to EXEC.
- EXEC: alu_q<=alu_result, npc_q<=nextpc, ld_q<=is_load, st_q<=is_store.
  - Priority 1: is_halt -> HALT, halted<=1, counted as retired (retire pulse, instret+1).
  - Priority 2: nextpc[1:0]!=0 -> HALT, fault<=1, halted<=1, not retired.
  - Priority 3: is_load|is_store -> MEM.
  - Otherwise -> WB.
- MEM: dmem_req=1, dmem_addr=alu_q, dmem_we=st_q, all held until dmem_ack. On ack, go to WB.
  - Load data is captured outside this block; rf_we for a load is issued in WB. The data path must therefore hold r_data until WB: data_mem registers its output on ack.
- WB: rf_we=reg_we for exactly one cycle; pc<=npc_q; retire=1; instret<=instret+1, wrapping to 0 at all-ones. Go to FETCH.
- HALT: terminal until rst. No requests, rf_we=0, pc frozen.
- Latency with zero-wait memory (ack in the same cycle as req): ALU/branch 4 cycles per instruction; load/store 5. Each memory wait cycle adds 1.
- Handshake rules:
  - Ack with req low is ignored.
  - req never drops before ack.
  - Memories share rst and must discard pending transactions on reset.
- Stores: rf_we stays 0 in WB regardless of reg_we (decoder guarantees reg_we=0).
- rf_we, dmem_req and imem_req are never high in the same cycle.
- Reset mid-MEM or mid-FETCH: request drops in the reset cycle; no retire, no rf_we.

Decomposition:
- Package cpu_mc_pkg: state encoding (S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4, S_HALT=5, 3-bit) and the NOP constant 32'h0000_0013. Added to define.vh alongside the existing ALU codes.
- One natural sub-module: mc_retire_cnt (CNT_W-bit counter with clear and increment) holding instret.

Test Plan:
- Reset then ADDI with imem_ack immediate, nextpc=pc+4 -> imem_req in cycle 0, rf_we and retire in cycle 3, pc 0->4, instret=1.
- LW at addr 0x100, dmem_ack after 3 wait cycles -> dmem_req high 4 cycles with dmem_addr=0x100 and dmem_we=0; rf_we in next cycle; total 8 cycles.
- SW with reg_we forced 1 -> dmem_we=1 during MEM, rf_we stays 0, retire=1.
- Halt instruction -> halted=1, retire pulse, instret+1; no further imem_req for 20 cycles; pc unchanged.
- Branch nextpc=0x0000_0006 -> fault=1, halted=1, no retire, pc unchanged.
- rst asserted during MEM wait; instret preset to 32'hFFFF_FFFF before a retire -> dmem_req low next cycle with state FETCH and pc=RESET_PC; separately, instret wraps to 0 on the retire.
